motor_pwm4: RTL
===============

# motor_pwm4

Four-channel motor PWM driver that sits directly downstream of the serial command parser. It consumes the four 8-bit sign-magnitude motor bytes, the four brake flags and a frame-complete strobe, and drives per-channel PWM, direction and brake pins for the H-bridge drivers. It adds glitch-free period-aligned duty updates, dead time on direction reversal, and a command watchdog that brakes all motors if frames stop arriving.

## Interface
- CLK_DIV, 4: clk cycles per PWM tick (≥1).
- DEAD_PERIODS, 2: full PWM periods with outputs off on direction reversal (≥1).
- WDT_CYCLES, 5000000: clk cycles without cmd_update before the watchdog trips (≥2).
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- motor1..motor4  in  8 each  bit7 = direction, bits[6:0] = duty magnitude 0..127.
- brake1..brake4  in  1 each  brake request per channel from the parser.
- cmd_update  in  1  one-clk pulse from the parser when a full frame has been accepted.
- pwm  out  4  PWM per channel; bit0 = motor1.
- dir  out  4  direction per channel.
- brk  out  4  brake pin per channel.
- wdt_tripped  out  1  high while the watchdog holds all channels in brake.

## Operation
- Prescaler: counts 0..CLK_DIV-1; tick = (prescaler == CLK_DIV-1).
- PWM counter: 7-bit, 0..126, advances on tick and wraps 126→0. Period = 127 ticks = 127·CLK_DIV clk. Shared by all channels.
- Period boundary (pb) = tick with counter == 126.
- pwm[i] = (state == RUN) && (counter < duty_sh[i]). Duty 0 gives constant low; duty 127 gives constant high.
- Per-channel FSM with states BRAKE, RUN, DEAD. Effective brake eff_brk[i] = brake_i | wdt_tripped.
  - Any state, eff_brk[i] = 1: go to BRAKE next clk. brk[i] = 1 and pwm[i] = 0 from that edge. Brake is not period-aligned.
  - BRAKE, eff_brk[i] = 0 at pb: load duty_sh = motor[6:0] and dir = motor[7], go to RUN. No dead time is needed, because the bridge was already off.
  - RUN at pb, motor[7] == dir: load duty_sh only.
  - RUN at pb, motor[7] != dir: go to DEAD, dead_cnt = 0, pwm low, dir held.
  - DEAD: dead_cnt increments at each pb. At the pb where dead_cnt == DEAD_PERIODS-1, load dir and duty_sh from the current inputs and go to RUN. If the inputs have reverted to the old direction by then, dir is unchanged.
- brk[i] = 1 only in BRAKE. Both DEAD and RUN drive brk[i] = 0.
- Watchdog: a counter of clk cycles.
  - cmd_update clears the counter and clears wdt_tripped.
  - When the counter reaches WDT_CYCLES-1, wdt_tripped is set and the counter saturates.
  - If cmd_update and expiry occur in the same cycle, cmd_update wins.

## Timing
- Reset (rst_n = 0 at a clk edge), on the next edge: pwm = 0, dir = 0, brk = 4'hF, wdt_tripped = 1, all FSMs in BRAKE, duty_sh = 0. The prescaler, PWM counter, dead_cnt and watchdog counter are all 0.
- The motors stay braked until the first cmd_update and then the next pb.
- Reset mid-DEAD or mid-RUN aborts immediately to the reset state.
- Duty/dir latency: new input values take effect on the first clk after the next pb. This is worst case one period + 1 clk.
- Brake latency: 1 clk from brake_i or wdt_tripped rising to brk[i] = 1 and pwm[i] = 0.
- Reversal: pwm[i] is low for exactly DEAD_PERIODS·127·CLK_DIV clk, measured from the pb where the change is seen to the new RUN period. dir toggles at the start of that new RUN period.
- Motor inputs are sampled only at pb. Changes between pbs are ignored, except that brake inputs are sampled every clk.

## Test plan
- Reset, then cmd_update, motor1 = 0x40, brake1 = 0 (CLK_DIV = 2): after the next pb, pwm[0] is high for 64 ticks (128 clk) of each 254-clk period; dir[0] = 0, brk[0] = 0.
- Duty limits: motor2 = 0x00 gives pwm[1] constant low with brk[1] = 0; motor2 = 0x7F gives pwm[1] constant high across the wrap.
- Reversal with DEAD_PERIODS = 2: motor3 goes 0x30 → 0xB0. pwm[2] is low for 2 full periods with dir[2] = 0, then dir[2] = 1 and duty 48. A reversal back to 0x30 during DEAD resumes RUN with dir[2] = 0.
- Brake mid-period: assert brake4 while pwm[3] is high. brk[3] = 1 and pwm[3] = 0 one clk later. Release it, and RUN resumes only at the next pb with no dead time, even if the direction changed.
- Watchdog with WDT_CYCLES = 1000: stop cmd_update. At clk 1000, wdt_tripped = 1 and brk = 4'hF. A cmd_update pulse clears the trip the next clk, and the channels rerun from the next pb. cmd_update coincident with expiry leaves wdt_tripped = 0.
- Reset asserted during DEAD: all outputs return to reset values on the next edge, and dir = 0.

Source files
------------

// File: rtl/motor_pwm4.sv
// Four-channel sign-magnitude PWM driver: period-aligned duty/dir updates, reversal dead time, command watchdog.
// Latency: duty/dir take effect on the clk after the next period boundary; brake 1 clk; no backpressure.
module motor_pwm4 #(
    parameter int CLK_DIV      = 4,
    parameter int DEAD_PERIODS = 2,
    parameter int WDT_CYCLES   = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] motor1,
    input  logic [7:0] motor2,
    input  logic [7:0] motor3,
    input  logic [7:0] motor4,
    input  logic       brake1,
    input  logic       brake2,
    input  logic       brake3,
    input  logic       brake4,
    input  logic       cmd_update,
    output logic [3:0] pwm,
    output logic [3:0] dir,
    output logic [3:0] brk,
    output logic       wdt_tripped
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
    localparam int WW = $clog2(WDT_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_PERIODS - 1);
    localparam logic [WW-1:0] WDT_LAST   = WW'(WDT_CYCLES - 1);
    localparam logic [6:0]    CNT_LAST   = 7'd126;

    typedef enum logic [1:0] {ST_BRAKE, ST_RUN, ST_DEAD} state_t;

    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    cnt_q, cnt_d;
    logic          tick, pb;
    logic [WW-1:0] wdt_cnt_q, wdt_cnt_d;
    logic          wdt_q, wdt_d;
    state_t        state_q [4];
    state_t        state_d [4];
    logic [6:0]    duty_q [4];
    logic [6:0]    duty_d [4];
    logic [DW-1:0] dead_q [4];
    logic [DW-1:0] dead_d [4];
    logic [3:0]    dir_q, dir_d, pwm_q, pwm_d, brk_q, brk_d;
    logic [7:0]    motor [4];
    logic [3:0]    brake_in;

    assign motor[0] = motor1;
    assign motor[1] = motor2;
    assign motor[2] = motor3;
    assign motor[3] = motor4;
    assign brake_in = {brake4, brake3, brake2, brake1};

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        pb      = tick && (cnt_q == CNT_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        cnt_d   = cnt_q;
        if (tick) begin
            cnt_d = (cnt_q == CNT_LAST) ? 7'd0 : cnt_q + 7'd1;
        end
    end

    // cmd_update has priority over expiry; the counter parks at its last value once tripped
    always_comb begin
        wdt_cnt_d = wdt_cnt_q;
        wdt_d     = wdt_q;
        if (cmd_update) begin
            wdt_cnt_d = '0;
            wdt_d     = 1'b0;
        end else if (wdt_cnt_q == WDT_LAST) begin
            wdt_d = 1'b1;
        end else begin
            wdt_cnt_d = wdt_cnt_q + 1'b1;
        end
    end

    always_comb begin
        pwm_d = '0;
        brk_d = '0;
        dir_d = dir_q;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            duty_d[i]  = duty_q[i];
            dead_d[i]  = dead_q[i];
            if (brake_in[i] || wdt_q) begin
                state_d[i] = ST_BRAKE;
            end else if (pb) begin
                case (state_q[i])
                    ST_BRAKE: begin
                        state_d[i] = ST_RUN;
                        duty_d[i]  = motor[i][6:0];
                        dir_d[i]   = motor[i][7];
                    end
                    ST_RUN: begin
                        if (motor[i][7] == dir_q[i]) begin
                            duty_d[i] = motor[i][6:0];
                        end else begin
                            state_d[i] = ST_DEAD;
                            dead_d[i]  = '0;
                        end
                    end
                    ST_DEAD: begin
                        if (dead_q[i] == DEAD_LAST) begin
                            state_d[i] = ST_RUN;
                            duty_d[i]  = motor[i][6:0];
                            dir_d[i]   = motor[i][7];
                        end else begin
                            dead_d[i] = dead_q[i] + 1'b1;
                        end
                    end
                    default: state_d[i] = ST_BRAKE;
                endcase
            end
            // Outputs are computed from next-state values so the pins are flops with no extra lag
            pwm_d[i] = (state_d[i] == ST_RUN) && (cnt_d < duty_d[i]);
            brk_d[i] = (state_d[i] == ST_BRAKE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q   <= '0;
            cnt_q     <= '0;
            wdt_cnt_q <= '0;
            wdt_q     <= 1'b1;
            dir_q     <= '0;
            pwm_q     <= '0;
            brk_q     <= 4'hF;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_BRAKE;
                duty_q[i]  <= '0;
                dead_q[i]  <= '0;
            end
        end else begin
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            wdt_cnt_q <= wdt_cnt_d;
            wdt_q     <= wdt_d;
            dir_q     <= dir_d;
            pwm_q     <= pwm_d;
            brk_q     <= brk_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                duty_q[i]  <= duty_d[i];
                dead_q[i]  <= dead_d[i];
            end
        end
    end

    assign pwm         = pwm_q;
    assign dir         = dir_q;
    assign brk         = brk_q;
    assign wdt_tripped = wdt_q;

endmodule
